// File: rtl/conm_soc_top.sv
// conm_soc_top: single-cycle RV32I SoC built from one core (u_CoNM),
// a byte-wide instruction ROM (imem) and a byte-wide data RAM (dmem).
// Programs are preloaded into imem.mem_unit from outside the design; the
// program reports its result through x26 (done), x27 (pass) and x3 (test id).
//
// Ports (top):
//   clk  in  1  system clock, all state changes on posedge
//   rst  in  1  asynchronous active-low reset
//
// Modules in this file:
//   conm_regfile  32x32 register file, 2 async read ports, 1 write port
//   conm_core     RV32I datapath + decode, one instruction per clock
//   conm_imem     combinational little-endian fetch from a byte array
//   conm_dmem     combinational read, byte-enabled posedge write

module conm_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  // regs[0] is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

module conm_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 12,
  parameter int          DMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic [31:0]        dmem_rdata
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] instr;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic        rd_we;
  logic [31:0] rd_val;
  logic        br_take;
  logic        imm_ok, op_ok;

  function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (fn)
      3'b000: r = alt ? (a - b) : (a + b);
      3'b001: r = a << b[4:0];
      3'b010: r = {31'b0, $signed(a) < $signed(b)};
      3'b011: r = {31'b0, a < b};
      3'b100: r = a ^ b;
      // Arithmetic shift kept in its own assignment so the signed operand
      // is not turned unsigned by a surrounding conditional expression.
      3'b101: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign instr     = imem_rdata;
  assign imem_addr = pc[IMEM_AW-1:0];
  assign pc_plus4  = pc + 32'd4;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shift-immediate and register ops only accept the funct7 patterns RV32I
  // defines; anything else falls through as a NOP.
  assign imm_ok = (f3 == 3'b001) ? (f7 == 7'h00) :
                  (f3 == 3'b101) ? ((f7 == 7'h00) || (f7 == 7'h20)) : 1'b1;
  assign op_ok  = (f7 == 7'h00) ||
                  ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));

  conm_regfile u_csregfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rd_we),
    .waddr  (rd),
    .wdata  (rd_val),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    br_take = 1'b0;
    case (f3)
      3'b000: br_take = (rs1_val == rs2_val);
      3'b001: br_take = (rs1_val != rs2_val);
      3'b100: br_take = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: br_take = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: br_take = (rs1_val <  rs2_val);
      3'b111: br_take = (rs1_val >= rs2_val);
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    pc_next    = pc_plus4;
    rd_we      = 1'b0;
    rd_val     = '0;
    dmem_be    = 4'b0000;
    dmem_addr  = DMEM_AW'(rs1_val + imm_i);
    dmem_wdata = rs2_val;
    case (opcode)
      OP_LUI: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OP_AUIPC: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc_plus4;
        pc_next = pc + imm_j;
      end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_val  = pc_plus4;
          pc_next = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (br_take) pc_next = pc + imm_b;
      end
      // dmem returns the four bytes starting at the effective address, so
      // every load width takes its data from the low lanes.
      OP_LOAD: begin
        rd_we = 1'b1;
        case (f3)
          3'b000:  rd_val = {{24{dmem_rdata[7]}}, dmem_rdata[7:0]};
          3'b001:  rd_val = {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
          3'b010:  rd_val = dmem_rdata;
          3'b100:  rd_val = {24'b0, dmem_rdata[7:0]};
          3'b101:  rd_val = {16'b0, dmem_rdata[15:0]};
          default: rd_we  = 1'b0;
        endcase
      end
      OP_STORE: begin
        dmem_addr = DMEM_AW'(rs1_val + imm_s);
        case (f3)
          3'b000:  dmem_be = 4'b0001;
          3'b001:  dmem_be = 4'b0011;
          3'b010:  dmem_be = 4'b1111;
          default: dmem_be = 4'b0000;
        endcase
      end
      OP_IMM: begin
        if (imm_ok) begin
          rd_we  = 1'b1;
          rd_val = alu(f3, (f3 == 3'b101) && instr[30], rs1_val, imm_i);
        end
      end
      OP_REG: begin
        if (op_ok) begin
          rd_we  = 1'b1;
          rd_val = alu(f3, instr[30], rs1_val, rs2_val);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_next;
  end
endmodule

module conm_imem #(
  parameter int IMEM_BYTES = 4096
) (
  input  logic [$clog2(IMEM_BYTES)-1:0] addr,
  output logic [31:0]                   rdata
);
  localparam int AW = $clog2(IMEM_BYTES);

  // Filled from outside the design; the design only reads it.
  logic [7:0] mem_unit [0:IMEM_BYTES-1];

  assign rdata = {mem_unit[addr + AW'(3)], mem_unit[addr + AW'(2)],
                  mem_unit[addr + AW'(1)], mem_unit[addr]};
endmodule

module conm_dmem #(
  parameter int DMEM_BYTES = 4096
) (
  input  logic                          clk,
  input  logic [$clog2(DMEM_BYTES)-1:0] addr,
  input  logic [31:0]                   wdata,
  input  logic [3:0]                    be,
  output logic [31:0]                   rdata
);
  localparam int AW = $clog2(DMEM_BYTES);

  logic [7:0]    mem_unit [0:DMEM_BYTES-1];
  logic [AW-1:0] lane [0:3];

  // Lane i addresses byte addr+i, wrapping within the RAM.
  always_comb begin
    for (int i = 0; i < 4; i++) lane[i] = addr + AW'(i);
  end

  assign rdata = {mem_unit[lane[3]], mem_unit[lane[2]], mem_unit[lane[1]], mem_unit[lane[0]]};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem_unit[lane[i]] <= wdata[8*i +: 8];
    end
  end
endmodule

module conm_soc_top #(
  parameter int          IMEM_BYTES = 4096,
  parameter int          DMEM_BYTES = 4096,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst
);
  localparam int IMEM_AW = $clog2(IMEM_BYTES);
  localparam int DMEM_AW = $clog2(DMEM_BYTES);

  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [3:0]         dmem_be;
  logic [31:0]        dmem_rdata;

  conm_core #(
    .RESET_PC (RESET_PC),
    .IMEM_AW  (IMEM_AW),
    .DMEM_AW  (DMEM_AW)
  ) u_CoNM (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata)
  );

  conm_imem #(.IMEM_BYTES(IMEM_BYTES)) imem (
    .addr  (imem_addr),
    .rdata (imem_rdata)
  );

  conm_dmem #(.DMEM_BYTES(DMEM_BYTES)) dmem (
    .clk   (clk),
    .addr  (dmem_addr),
    .wdata (dmem_wdata),
    .be    (dmem_be),
    .rdata (dmem_rdata)
  );
endmodule

// File: tb/tb_conm_soc_top.sv
module tb_conm_soc_top;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #10 clk = ~clk;

  conm_soc_top dut (
    .clk (clk),
    .rst (rst)
  );

  // Instruction-level reference: architectural state only.
  logic [7:0]  m_imem [0:4095];
  logic [7:0]  m_dmem [0:4095];
  logic [31:0] m_x    [0:31];
  logic [31:0] m_pc;

  int n_vec;
  int n_bad;
  int pa;

  function automatic logic [31:0] dreg(input int i);
    return dut.u_CoNM.u_csregfile.regs[i];
  endfunction

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] e_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_u(input int imm20, input int rd, input int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] e_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return e_i(imm, rs1, 0, rd, 'h13);
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      dut.imem.mem_unit[addr + k] = w[8*k +: 8];
      m_imem[addr + k]            = w[8*k +: 8];
    end
  endtask

  task automatic emit(input logic [31:0] w);
    put(pa, w);
    pa = pa + 4;
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 4096; a += 4) put(a, 32'h0000_0013);
    pa = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
  endtask

  // One architectural instruction, straight from the ISA definitions.
  task automatic model_step();
    logic [11:0] p, ea;
    logic [31:0] ins, a, b, src2, res, nxt, immI, immS, immB, immU, immJ, w;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  sh;
    logic        wr, ok;
    int          rd, n;
    p    = m_pc[11:0];
    ins  = {m_imem[12'(p + 3)], m_imem[12'(p + 2)], m_imem[12'(p + 1)], m_imem[p]};
    op   = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    rd   = int'(ins[11:7]);
    a    = m_x[ins[19:15]];
    b    = m_x[ins[24:20]];
    immI = 32'($signed(ins) >>> 20);
    immS = {immI[31:5], ins[11:7]};
    immB = {immI[31:12], ins[7], ins[30:25], ins[11:8], 1'b0};
    immU = {ins[31:12], 12'h000};
    immJ = {immI[31:20], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt  = m_pc + 32'd4;
    wr   = 1'b0;
    res  = 32'h0;
    case (op)
      7'h37: begin wr = 1'b1; res = immU; end
      7'h17: begin wr = 1'b1; res = m_pc + immU; end
      7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + immJ; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + immI) & 32'hFFFF_FFFE; end
      7'h63: begin
        ok = 1'b0;
        case (f3)
          3'd0: ok = (a == b);
          3'd1: ok = (a != b);
          3'd4: ok = ((a ^ 32'h8000_0000) <  (b ^ 32'h8000_0000));
          3'd5: ok = ((a ^ 32'h8000_0000) >= (b ^ 32'h8000_0000));
          3'd6: ok = (a <  b);
          3'd7: ok = (a >= b);
          default: ok = 1'b0;
        endcase
        if (ok) nxt = m_pc + immB;
      end
      7'h03: begin
        ea = 12'(a + immI);
        w  = {m_dmem[12'(ea + 3)], m_dmem[12'(ea + 2)], m_dmem[12'(ea + 1)], m_dmem[ea]};
        wr = 1'b1;
        case (f3)
          3'd0: res = 32'($signed(w[7:0]));
          3'd1: res = 32'($signed(w[15:0]));
          3'd2: res = w;
          3'd4: res = w & 32'h0000_00FF;
          3'd5: res = w & 32'h0000_FFFF;
          default: wr = 1'b0;
        endcase
      end
      7'h23: begin
        ea = 12'(a + immS);
        n  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        for (int k = 0; k < n; k++) m_dmem[12'(ea + k)] = b[8*k +: 8];
      end
      7'h13, 7'h33: begin
        src2 = (op == 7'h33) ? b : immI;
        sh   = src2[4:0];
        if (op == 7'h33)
          ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else
          ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        wr = ok;
        case (f3)
          3'd0: res = (op == 7'h33 && ins[30]) ? a - src2 : a + src2;
          3'd1: res = a << sh;
          3'd2: res = ((a ^ 32'h8000_0000) < (src2 ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
          3'd3: res = (a < src2) ? 32'd1 : 32'd0;
          3'd4: res = a ^ src2;
          3'd5: res = (a >> sh) | ((ins[30] && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
          3'd6: res = a | src2;
          default: res = a & src2;
        endcase
      end
      default: ;
    endcase
    if (wr && rd != 0) m_x[rd] = res;
    m_pc = nxt;
  endtask

  task automatic check_regs(input string tag);
    int bad;
    bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && dreg(i) !== m_x[i]) bad = i;
    n_vec++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s: x%0d dut=%h model=%h", tag, bad, dreg(bad), m_x[bad]);
    end
  endtask

  task automatic pin(input string nm, input int r, input logic [31:0] exp);
    n_vec++;
    if (dreg(r) !== exp || m_x[r] !== exp) begin
      n_bad++;
      $display("FAIL %s: x%0d dut=%h model=%h required=%h", nm, r, dreg(r), m_x[r], exp);
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_step();
      @(negedge clk);
      check_regs(tag);
    end
  endtask

  task automatic start_prog(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_regs(tag);
    clear_imem();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    n_vec = 0;
    n_bad = 0;

    // ---- ADDI wrap and x0 immutability ----
    start_prog("reset_p1");
    emit(addi(1, 0, -1));
    emit(addi(2, 1, 1));
    emit(addi(0, 0, 5));
    emit(addi(4, 0, 'h123));
    #40;
    release_rst();
    pin("pre_first_edge", 1, 32'h0);
    run(1, "p1");
    pin("first_retire", 1, 32'hFFFF_FFFF);
    pin("first_retire_x2", 2, 32'h0);
    run(6, "p1");
    pin("addi_m1", 1, 32'hFFFF_FFFF);
    pin("addi_wrap", 2, 32'h0);
    pin("x0_const", 0, 32'h0);
    pin("addi_pos", 4, 32'h123);

    // ---- shifts, compares, branches ----
    start_prog("reset_p2");
    emit(e_u('h80000, 5, 'h37));
    emit(e_i('h41F, 5, 5, 6, 'h13));
    emit(e_i(31, 5, 5, 7, 'h13));
    emit(addi(6, 0, 1));
    emit(e_r(0, 6, 5, 2, 8));
    emit(e_r(0, 6, 5, 3, 9));
    emit(e_b(8, 6, 5, 4));
    emit(addi(11, 0, 7));
    emit(addi(12, 0, 9));
    emit(e_b(8, 6, 5, 7));
    emit(addi(13, 0, 1));
    emit(e_b(8, 0, 0, 1));
    emit(addi(14, 0, 3));
    emit(e_b(0, 0, 0, 0));
    release_rst();
    run(3, "p2");
    pin("lui", 5, 32'h8000_0000);
    pin("srai", 6, 32'hFFFF_FFFF);
    pin("srli", 7, 32'h0000_0001);
    run(20, "p2");
    pin("slt", 8, 32'h1);
    pin("sltu", 9, 32'h0);
    pin("blt_skip", 11, 32'h0);
    pin("blt_target", 12, 32'h9);
    pin("bgeu_skip", 13, 32'h0);
    pin("bne_fall", 14, 32'h3);

    // ---- loads and stores ----
    start_prog("reset_p3");
    emit(e_u('h11223, 1, 'h37));
    emit(addi(1, 1, 'h344));
    emit(addi(2, 0, 'h100));
    emit(e_s(0, 1, 2, 2));
    emit(e_i(3, 2, 0, 3, 'h03));
    emit(e_i(0, 2, 5, 4, 'h03));
    emit(addi(5, 0, -128));
    emit(e_s(1, 5, 2, 0));
    emit(e_i(1, 2, 0, 6, 'h03));
    emit(e_i(0, 2, 2, 7, 'h03));
    emit(e_i(0, 2, 1, 8, 'h03));
    emit(e_i(1, 2, 4, 9, 'h03));
    emit(e_s(2, 5, 2, 1));
    emit(e_i(0, 2, 2, 10, 'h03));
    emit(e_j(0, 0));
    release_rst();
    run(20, "p3");
    pin("lb_hi", 3, 32'h0000_0011);
    pin("lhu", 4, 32'h0000_3344);
    pin("lb_sext", 6, 32'hFFFF_FF80);
    pin("lw_after_sb", 7, 32'h1122_8044);
    pin("lh_sext", 8, 32'hFFFF_8044);
    pin("lbu", 9, 32'h0000_0080);
    pin("lw_after_sh", 10, 32'hFF80_8044);

    // ---- jumps, R-type, done/pass flags, mid-run reset ----
    start_prog("reset_p4");
    emit(addi(3, 0, 1));
    emit(e_u(1, 15, 'h17));
    emit(e_j('h18, 0));
    pa = 'h20;
    emit(e_j(12, 1));
    emit(addi(3, 0, 2));
    emit(e_j(12, 0));
    emit(addi(16, 0, 5));
    emit(e_i(0, 1, 0, 0, 'h67));
    emit(addi(20, 0, 'hF0));
    emit(addi(21, 0, 'hFF));
    emit(e_r(0, 21, 20, 4, 22));
    emit(e_r(0, 21, 20, 7, 23));
    emit(e_r('h20, 21, 20, 0, 24));
    emit(e_r('h20, 20, 24, 5, 25));
    emit(e_r(0, 20, 21, 1, 28));
    emit(addi(27, 0, 1));
    emit(addi(26, 0, 1));
    emit(32'h0000_0073);
    emit(e_j(0, 0));
    release_rst();
    run(5, "p4a");
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_regs("midrun_reset");
    pin("midrun_x1", 1, 32'h0);
    release_rst();
    k = 0;
    while (dreg(26) !== 32'h1 && k < 2500) begin
      run(1, "p4");
      k++;
    end
    n_vec++;
    if (k >= 2500) begin
      n_bad++;
      $display("FAIL done_timeout: x26=%h after %0d cycles, required 00000001", dreg(26), k);
    end
    run(4, "p4");
    pin("jal_link", 1, 32'h0000_0024);
    pin("jal_target", 16, 32'h0000_0005);
    pin("jalr_return", 3, 32'h0000_0002);
    pin("auipc", 15, 32'h0000_1004);
    pin("xor", 22, 32'h0000_000F);
    pin("and", 23, 32'h0000_00F0);
    pin("sub", 24, 32'hFFFF_FFF1);
    pin("sra", 25, 32'hFFFF_FFFF);
    pin("sll", 28, 32'h00FF_0000);
    pin("pass", 27, 32'h0000_0001);
    pin("done", 26, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
